// File: rtl/pipe_pkg.sv
// Shared definitions for the two-entry pipeline stage register:
// state encoding, default widths and the state-to-occupancy mapping.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 9;
    localparam int CNT_W_DEF  = 16;

    function automatic logic [1:0] occupancy_of(input pipe_state_e st);
        logic [1:0] occ;
        case (st)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One held entry of the stage: control plus data register with load enable.
// Clear zeroes only the control field so a squashed slot reads as a bubble.
module pipe_slot #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic              clr,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;

    // slot storage: reset clears all, clear wins over load and spares data
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r <= {CTRL_W{1'b0}};
            data_r <= {DATA_W{1'b0}};
        end else if (clr) begin
            ctrl_r <= {CTRL_W{1'b0}};
        end else if (ld) begin
            ctrl_r <= d_ctrl;
            data_r <= d_data;
        end else begin
            ctrl_r <= ctrl_r;
            data_r <= data_r;
        end
    end

    assign q_ctrl = ctrl_r;
    assign q_data = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with registered in_ready,
// flush squash, bubble-zeroed control output and a saturating stall counter.
module pipe_stage_reg #(
    parameter int DATA_W = pipe_pkg::DATA_W_DEF,
    parameter int CTRL_W = pipe_pkg::CTRL_W_DEF,
    parameter int CNT_W  = pipe_pkg::CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    import pipe_pkg::*;

    pipe_state_e       state_r, state_s;
    logic              in_ready_r, out_valid_r;
    logic [1:0]        occupancy_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              accept_s, take_s;
    logic              main_ld_s, main_clr_s, skid_ld_s, skid_clr_s, main_sel_skid_s;
    logic [CTRL_W-1:0] main_ctrl_s, skid_ctrl_s, main_d_ctrl_s;
    logic [DATA_W-1:0] main_data_s, skid_data_s, main_d_data_s;

    assign accept_s = in_valid & in_ready_r;
    assign take_s   = out_valid_r & out_ready;

    // next-state and slot control; flush overrides every handshake event
    always_comb begin
        state_s         = state_r;
        main_ld_s       = 1'b0;
        main_clr_s      = 1'b0;
        skid_ld_s       = 1'b0;
        skid_clr_s      = 1'b0;
        main_sel_skid_s = 1'b0;
        if (flush) begin
            state_s    = ST_EMPTY;
            main_clr_s = 1'b1;
            skid_clr_s = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_s   = ST_ONE;
                        main_ld_s = 1'b1;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && take_s) begin
                        main_ld_s = 1'b1;
                    end else if (accept_s) begin
                        state_s   = ST_FULL;
                        skid_ld_s = 1'b1;
                    end else if (take_s) begin
                        // zero ctrl so the empty stage presents a clean bubble
                        state_s    = ST_EMPTY;
                        main_clr_s = 1'b1;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (take_s) begin
                        state_s         = ST_ONE;
                        main_ld_s       = 1'b1;
                        main_sel_skid_s = 1'b1;
                        skid_clr_s      = 1'b1;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s    = ST_EMPTY;
                    main_clr_s = 1'b1;
                    skid_clr_s = 1'b1;
                end
            endcase
        end
    end

    // main slot refills from skid when draining FULL, otherwise from upstream
    always_comb begin
        main_d_ctrl_s = in_ctrl;
        main_d_data_s = in_data;
        if (main_sel_skid_s) begin
            main_d_ctrl_s = skid_ctrl_s;
            main_d_data_s = skid_data_s;
        end else begin
            main_d_ctrl_s = in_ctrl;
            main_d_data_s = in_data;
        end
    end

    // state plus status outputs registered together from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s != ST_FULL);
            out_valid_r <= (state_s != ST_EMPTY);
            occupancy_r <= occupancy_of(state_s);
        end
    end

    // saturating count of stalled cycles; flush deliberately leaves it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .ld     (main_ld_s),
        .clr    (main_clr_s),
        .d_ctrl (main_d_ctrl_s),
        .d_data (main_d_data_s),
        .q_ctrl (main_ctrl_s),
        .q_data (main_data_s)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .ld     (skid_ld_s),
        .clr    (skid_clr_s),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .q_ctrl (skid_ctrl_s),
        .q_data (skid_data_s)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_ctrl  = main_ctrl_s;
    assign out_data  = main_data_s;
    assign occupancy = occupancy_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the driver queues expected entries on
// accept, a negedge monitor pops and compares whatever the stage presents.
module tb_pipe_stage_reg;

    typedef struct {
        logic [8:0]  ctrl;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [8:0]  in_ctrl, out_ctrl;
    logic [31:0] in_data, out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        s_in_valid, s_in_ready, s_out_valid;
    logic [8:0]  s_out_ctrl;
    logic [31:0] s_in_data, s_out_data;
    logic [1:0]  s_occupancy;
    logic [3:0]  s_stall_cnt;

    ent_t        exp_q[$];
    logic [15:0] exp_stall = 16'd0;
    logic        mon_en = 1'b0;
    logic        mon_ready = 1'b1;
    int          sz;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(9), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(9'h0A5), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(1'b0), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] ctrl_of(input logic [31:0] d);
        return {d[7:0], 1'b1};
    endfunction

    // monitor: compare presented head against the scoreboard, then advance the model
    always @(negedge clk) begin
        if (mon_en) begin
            sz = exp_q.size();
            check("in_ready", {63'd0, in_ready}, {63'd0, sz < 2});
            check("out_valid", {63'd0, out_valid}, {63'd0, sz != 0});
            check("occupancy", {62'd0, occupancy}, 64'(sz));
            check("stall_cnt", {48'd0, stall_cnt}, {48'd0, exp_stall});
            if (sz == 0) begin
                check("out_ctrl_bubble", {55'd0, out_ctrl}, 64'd0);
            end else begin
                check("out_ctrl", {55'd0, out_ctrl}, {55'd0, exp_q[0].ctrl});
                check("out_data", {32'd0, out_data}, {32'd0, exp_q[0].data});
            end
            mon_ready = (sz < 2);
            if (rst) begin
                exp_q.delete();
                exp_stall = 16'd0;
            end else begin
                if (sz != 0 && !out_ready && exp_stall != 16'hFFFF) exp_stall++;
                if (sz != 0 && out_ready) void'(exp_q.pop_front());
                if (flush) exp_q.delete();
            end
        end
    end

    // one cycle of stimulus; called at posedge+1, returns at the next posedge+1
    task automatic cyc(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
        ent_t e;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = ctrl_of(d);
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        #1;
        if (v && mon_ready && !fl && !rst) begin
            e.ctrl = ctrl_of(d);
            e.data = d;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; in_ctrl = 9'h1FF;
        out_ready = 1'b0; s_in_valid = 1'b0; s_in_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_ctrl", {55'd0, out_ctrl}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
        check("rst_occupancy", {62'd0, occupancy}, 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        mon_en = 1'b1;

        // streaming 1..8 with downstream always ready
        for (int i = 1; i <= 8; i++) cyc(1'b1, 32'(i), 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // back-pressure: A,B held, C refused until drain
        cyc(1'b1, 32'hA, 1'b0, 1'b0);
        cyc(1'b1, 32'hB, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, 32'hC, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, 32'hC, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // flush while FULL with an incoming entry
        cyc(1'b1, 32'hD, 1'b0, 1'b0);
        cyc(1'b1, 32'hE, 1'b0, 1'b0);
        cyc(1'b1, 32'hF, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // flush together with take from ONE
        cyc(1'b1, 32'h61, 1'b0, 1'b0);
        cyc(1'b1, 32'h62, 1'b1, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // reset mid-operation, then first accept from EMPTY
        cyc(1'b1, 32'h71, 1'b0, 1'b0);
        cyc(1'b1, 32'h72, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 32'h73, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b1, 32'h74, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // mixed valid/ready/flush traffic
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 1)), 32'h1000 + 32'(i),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        repeat (3) cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // 4-bit stall counter saturation on the second instance
        s_in_valid = 1'b1;
        s_in_data  = 32'h55;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        check("sat_start", {60'd0, s_stall_cnt}, 64'd0);
        check("sat_valid", {63'd0, s_out_valid}, 64'd1);
        repeat (10) @(posedge clk);
        #1;
        check("sat_mid", {60'd0, s_stall_cnt}, 64'd10);
        repeat (10) @(posedge clk);
        #1;
        check("sat_end", {60'd0, s_stall_cnt}, 64'd15);
        check("sat_data_held", {32'd0, s_out_data}, 64'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of datapath payload (PC, operands, immediate, register IDs packed by the instantiating stage).
REQ-002 SHALL have parameter CTRL_W, default 9: width of control-signal payload (WB/M/EX fields packed by the instantiating stage).
REQ-003 SHALL have parameter CNT_W, default 16: width of stall counter.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  kill all held entries (branch/exception squash).
REQ-007 in_valid  input  1  upstream presents an entry.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 in_ctrl  input  CTRL_W  upstream control payload.
REQ-010 in_data  input  DATA_W  upstream data payload.
REQ-011 out_valid  output  1  head entry valid.
REQ-012 out_ready  input  1  downstream accepts head entry.
REQ-013 out_ctrl  output  CTRL_W  head control payload; all-zero (bubble) whenever out_valid=0.
REQ-014 out_data  output  DATA_W  head data payload.
REQ-015 occupancy  output  2  number of held entries, 0..2.
REQ-016 stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 SHALL hold up to two entries: main slot (drives outputs) and skid slot; order SHALL be strictly FIFO.
REQ-018 SHALL implement states EMPTY (0 entries), ONE (main valid), FULL (main+skid valid).
REQ-019 in_ready SHALL be a registered function of state: 1 in EMPTY/ONE, 0 in FULL; never combinationally dependent on out_ready.
REQ-020 Accept = in_valid & in_ready; take = out_valid & out_ready.
REQ-021 EMPTY: accept -> ONE, main <= input.
REQ-022 ONE: accept & take -> ONE, main <= input; accept & !take -> FULL, skid <= input; !accept & take -> EMPTY; neither -> hold.
REQ-023 FULL: take -> ONE, main <= skid; !take -> hold all contents.
REQ-024 Latency: entry accepted in cycle N SHALL appear on out_* in cycle N+1 when stage was EMPTY or ONE-with-take.
REQ-025 Sustained throughput SHALL be one entry per cycle while out_ready=1.
REQ-026 out_valid = (state != EMPTY); occupancy = 0/1/2 for EMPTY/ONE/FULL.
REQ-027 out_ctrl SHALL be forced to zero whenever out_valid=0; out_data value is don't-care when out_valid=0 but SHALL be stable (no toggling) while held.
REQ-028 flush SHALL have priority over all handshake events: next state EMPTY, both slots' control fields cleared, any input accepted that cycle discarded, data fields unchanged.
REQ-029 flush together with take: the taken entry SHALL count as consumed by downstream; nothing else survives.
REQ-030 stall_cnt SHALL increment by 1 each cycle with out_valid=1 & out_ready=0, saturating at 2^CNT_W-1; flush SHALL NOT clear it.
REQ-031 Held payload SHALL NOT change while out_valid=1 & out_ready=0 (stall hold, replacing legacy enable-gated hold).

Reset
REQ-032 rst SHALL dominate flush and handshake: state EMPTY, in_ready=1, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, both slots' ctrl and data cleared.
REQ-033 rst asserted mid-operation (ONE or FULL) SHALL discard all held entries on the next edge; first post-reset accept SHALL behave as from EMPTY.

Structure
REQ-034 State encoding (EMPTY/ONE/FULL enum, 2 bits) and default width constants SHALL live in shared package pipe_pkg.
REQ-035 One sub-module is natural: pipe_slot (CTRL_W+DATA_W register with load enable and ctrl-only clear), instantiated twice for main and skid.
REQ-036 Per-stage field packing (e.g. {EX,M,WB} control) SHALL be done in the instantiating stage, not in this block.

Verification
REQ-037 Reset: rst=1 two cycles with in_valid=1, in_data=0xDEAD -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0.
REQ-038 Streaming: out_ready=1, push data 1..8 back-to-back -> out_data 1..8 on consecutive cycles, one cycle later, occupancy never 2.
REQ-039 Back-pressure: push A,B,C with out_ready=0 -> A,B held, in_ready=0 after B, C not accepted until out_ready=1; output order A,B,C; stall_cnt advances once per stalled cycle.
REQ-040 Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; flushed and incoming entries never appear.
REQ-041 Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-042 Random valid/ready/flush against scoreboard -> no loss, duplication or reordering of non-flushed entries; out_ctrl=0 whenever out_valid=0.
